// File: rtl/pb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pb_pkg
//  Description : Shared types and constants for the push-button counter
//                scheduler. Holds the update FSM state encoding, the digit
//                limit, the lockout timer width and the round-robin picker.
//  Revision    : 1.0  initial release
// ============================================================================
package pb_pkg;

  localparam int MAX_DIGITS = 4;
  localparam int LOCK_W     = 25;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    STEP = 1'b1
  } state_t;

  // Round-robin pick: returns {found, index}. It chooses the first pending
  // index at or above ptr, wrapping modulo n. The loop runs from the highest
  // offset down so that the smallest offset is the one that sticks.
  function automatic logic [2:0] rr_pick(input logic [MAX_DIGITS-1:0] pend,
                                         input logic [1:0]            ptr,
                                         input int                    n);
    logic [2:0] res;
    int         c;
    res = '0;
    c   = 0;
    for (int off = MAX_DIGITS - 1; off >= 0; off--) begin
      if (off < n) begin
        c = (int'(ptr) + off) % n;
        if (pend[c[1:0]]) begin
          res = {1'b1, c[1:0]};
        end
      end
    end
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pb_edge_lock.sv
`default_nettype none
// ============================================================================
//  Module      : pb_edge_lock
//  Description : One push-button front end: 2-flop synchronizer, rising-edge
//                detector, re-trigger lockout timer and a sticky pending flag
//                that the scheduler clears when it grants this button.
//  Ports       : clk      - system clock
//                rst      - synchronous, active-low reset
//                pb_raw   - raw asynchronous button input
//                en       - button is in use (tied low for unused digits)
//                clr      - clear the pending flag (grant for this button)
//                pending  - button press waiting for service
//  Revision    : 1.0  initial release
// ============================================================================
module pb_edge_lock
  import pb_pkg::*;
#(
  parameter logic [LOCK_W-1:0] LOCK_CYCLES = 25'h1FFFFFF
) (
  input  logic clk,
  input  logic rst,
  input  logic pb_raw,
  input  logic en,
  input  logic clr,
  output logic pending
);

  logic              sync1;
  logic              sync2;
  logic              sync_prev;
  logic [LOCK_W-1:0] timer;
  logic              rise;
  logic              take;

  assign rise = sync2 & ~sync_prev;
  // An edge counts only when the lockout has fully expired.
  assign take = rise & en & (timer == '0);

  always_ff @(posedge clk) begin
    if (!rst) begin
      // Synchronizer resets to 0 so a button held through reset release
      // still produces exactly one edge.
      sync1     <= 1'b0;
      sync2     <= 1'b0;
      sync_prev <= 1'b0;
      timer     <= '0;
      pending   <= 1'b0;
    end else begin
      sync1     <= pb_raw;
      sync2     <= sync1;
      sync_prev <= sync2;

      if (take) begin
        timer <= LOCK_CYCLES;
      end else if (timer != '0) begin
        timer <= timer - 1'b1;
      end

      // A new capture wins over a clear in the same cycle so no press is lost.
      if (take) begin
        pending <= 1'b1;
      end else if (clr) begin
        pending <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/pb_cnt_sched.sv
`default_nettype none
// ============================================================================
//  Module      : pb_cnt_sched
//  Description : Push-button driven hex counter. Each button requests an
//                increment of its digit; requests are served round-robin by a
//                two-state update FSM that can ripple a carry one digit per
//                cycle when carry_en is high.
//  Ports       : clk      - system clock, rising edge
//                rst      - synchronous, active-low reset
//                pb       - raw buttons, pb[i] requests digit i
//                carry_en - 1: digits cascade, 0: digits independent
//                cnt_out  - digit i at bits [4i+3:4i]
//                grant    - one-hot single-cycle pulse of serviced button
//                busy     - FSM is in STEP
//                ovf      - top digit wrapped F->0 in carry mode
//  Revision    : 1.0  initial release
// ============================================================================
module pb_cnt_sched
  import pb_pkg::*;
#(
  parameter int                DIGITS      = 4,
  parameter logic [LOCK_W-1:0] LOCK_CYCLES = 25'h1FFFFFF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [3:0]            pb,
  input  logic                  carry_en,
  output logic [4*DIGITS-1:0]   cnt_out,
  output logic [3:0]            grant,
  output logic                  busy,
  output logic                  ovf
);

  localparam logic [1:0] LAST_IDX = 2'(DIGITS - 1);

  state_t                state;
  state_t                state_nxt;
  logic [MAX_DIGITS-1:0] pending;
  logic [MAX_DIGITS-1:0] pend_clr;
  logic [1:0]            rr_ptr;
  logic [1:0]            idx;
  logic [3:0]            digit [MAX_DIGITS];
  logic [2:0]            pick;
  logic                  digit_f;

  // --------------------------------------------------------------------------
  // Button front ends. All four are built; those above DIGITS are disabled so
  // they never raise a pending request.
  // --------------------------------------------------------------------------
  generate
    for (genvar i = 0; i < MAX_DIGITS; i++) begin : g_btn
      pb_edge_lock #(
        .LOCK_CYCLES (LOCK_CYCLES)
      ) u_lock (
        .clk     (clk),
        .rst     (rst),
        .pb_raw  (pb[i]),
        .en      (i < DIGITS),
        .clr     (pend_clr[i]),
        .pending (pending[i])
      );
    end
  endgenerate

  assign pick    = rr_pick(pending, rr_ptr, DIGITS);
  assign digit_f = (digit[idx] == 4'hF);
  assign busy    = (state == STEP);

  // --------------------------------------------------------------------------
  // FSM next state and pulse outputs
  // --------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    grant     = '0;
    pend_clr  = '0;
    ovf       = 1'b0;
    case (state)
      IDLE: begin
        if (pick[2]) begin
          grant     = 4'b0001 << pick[1:0];
          pend_clr  = grant;
          state_nxt = STEP;
        end
      end
      STEP: begin
        // carry_en is looked at every step, so it can stop a chain midway.
        if (carry_en && digit_f) begin
          if (idx == LAST_IDX) begin
            ovf       = 1'b1;
            state_nxt = IDLE;
          end
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // State, pointer and digit registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= IDLE;
      rr_ptr <= 2'd0;
      idx    <= 2'd0;
      for (int d = 0; d < MAX_DIGITS; d++) begin
        digit[d] <= 4'h0;
      end
    end else begin
      state <= state_nxt;

      if (state == IDLE && pick[2]) begin
        idx    <= pick[1:0];
        rr_ptr <= (pick[1:0] == LAST_IDX) ? 2'd0 : pick[1:0] + 2'd1;
      end

      if (state == STEP) begin
        digit[idx] <= digit[idx] + 4'd1;
        if (carry_en && digit_f && idx != LAST_IDX) begin
          idx <= idx + 2'd1;
        end
      end
    end
  end

  generate
    for (genvar i = 0; i < DIGITS; i++) begin : g_out
      assign cnt_out[4*i +: 4] = digit[i];
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_pb_cnt_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pb_cnt_sched
//  Description : Scoreboard bench for pb_cnt_sched (DIGITS=4, LOCK_CYCLES=8)
//                plus a DIGITS=2 instance for the unused-button case.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pb_cnt_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  pb = '0;
  logic        carry_en = 1'b0;
  logic [15:0] cnt_out;
  logic [3:0]  grant;
  logic        busy;
  logic        ovf;

  logic [3:0]  pb2 = '0;
  logic [7:0]  cnt2;
  logic [3:0]  grant2;
  logic        busy2;
  logic        ovf2;

  always #5 clk = ~clk;

  pb_cnt_sched #(.DIGITS(4), .LOCK_CYCLES(25'd8)) dut (
    .clk(clk), .rst(rst), .pb(pb), .carry_en(carry_en),
    .cnt_out(cnt_out), .grant(grant), .busy(busy), .ovf(ovf)
  );

  pb_cnt_sched #(.DIGITS(2), .LOCK_CYCLES(25'd8)) dut2 (
    .clk(clk), .rst(rst), .pb(pb2), .carry_en(1'b0),
    .cnt_out(cnt2), .grant(grant2), .busy(busy2), .ovf(ovf2)
  );

  typedef struct {
    logic [3:0]  g;
    int          blen;
    logic [15:0] cnt;
    int          novf;
  } txn_t;

  txn_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // --------------------------------------------------------------------------
  // Monitor: pops an expected transaction on each grant, closes it when busy
  // drops, and checks busy length, final count and ovf pulses.
  // --------------------------------------------------------------------------
  logic prev_busy = 1'b0;
  bit   in_txn = 1'b0;
  txn_t cur;
  int   blen = 0;
  int   novf = 0;

  always @(negedge clk) begin
    if (in_txn && prev_busy && !busy) begin
      chk("busy_len", blen, cur.blen);
      chk("cnt_out", cnt_out, cur.cnt);
      chk("ovf_count", novf, cur.novf);
      in_txn = 1'b0;
    end
    if (grant != 4'b0000) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_grant", grant, 4'b0000);
      end else begin
        cur = exp_q.pop_front();
        chk("grant", grant, cur.g);
        in_txn = 1'b1;
        blen   = 0;
        novf   = 0;
      end
    end
    if (busy) blen++;
    if (ovf) begin
      novf++;
      if (!in_txn) chk("stray_ovf", ovf, 1'b0);
    end
    prev_busy = busy;
  end

  task automatic push(input logic [3:0] g, input int bl, input logic [15:0] c, input int no);
    txn_t t;
    t.g = g; t.blen = bl; t.cnt = c; t.novf = no;
    exp_q.push_back(t);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b0; pb = '0; pb2 = '0;
    tick(2);
    rst = 1'b1;
    exp_cnt = 16'h0000;
  endtask

  task automatic press(input logic [3:0] mask);
    @(posedge clk); #1 pb = mask;
    @(posedge clk); #1 pb = '0;
  endtask

  task automatic wait_idle(input int budget);
    bit done;
    done = 1'b0;
    for (int n = 0; n < budget && !done; n++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !in_txn && !busy) done = 1'b1;
    end
    if (!done) chk("wait_idle_timeout", 1, 0);
  endtask

  // Repeated presses with carry off; expected values step one digit at a time.
  task automatic fill(input logic [3:0] mask, input int rounds);
    for (int r = 0; r < rounds; r++) begin
      for (int k = 0; k < 4; k++) begin
        if (mask[k]) begin
          exp_cnt = exp_cnt + (16'h0001 << (4 * k));
          push(4'b0001 << k, 1, exp_cnt, 0);
        end
      end
      press(mask);
      wait_idle(60);
      tick(10);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1);
  end

  initial begin
    int  n;
    bit  seen;

    // Reset state
    tick(3);
    @(negedge clk);
    chk("reset_cnt", cnt_out, 16'h0000);
    chk("reset_grant", grant, 4'b0000);
    chk("reset_busy", busy, 1'b0);
    chk("reset_ovf", ovf, 1'b0);
    rst = 1'b1;
    exp_cnt = 16'h0000;

    // Single press, carry off: grant 3 cycles after pb rises
    carry_en = 1'b0;
    push(4'b0001, 1, 16'h0001, 0);
    @(posedge clk); #1 pb = 4'b0001;
    n = 0;
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(posedge clk);
      n++;
      if (n == 1) #1 pb = 4'b0000;
      @(negedge clk);
      if (grant != 4'b0000) seen = 1'b1;
    end
    chk("grant_latency", n, 3);
    wait_idle(40);

    // Lockout: second pulse 4 cycles later dropped, third 12 cycles later taken
    do_reset();
    push(4'b0001, 1, 16'h0001, 0);
    push(4'b0001, 1, 16'h0002, 0);
    @(posedge clk); #1 pb = 4'b0001;
    tick(1); pb = 4'b0000;
    tick(3); pb = 4'b0001;
    tick(1); pb = 4'b0000;
    tick(7); pb = 4'b0001;
    tick(1); pb = 4'b0000;
    wait_idle(60);
    tick(10);

    // All four buttons at once: round-robin order 0,1,2,3
    do_reset();
    fill(4'b1111, 1);

    // 0x0FFF + 1 with carry: four steps, no overflow
    do_reset();
    fill(4'b0111, 15);
    carry_en = 1'b1;
    push(4'b0001, 4, 16'h1000, 0);
    press(4'b0001);
    wait_idle(60);
    tick(10);

    // 0xFFFF + 1 with carry: wraps to 0 with one ovf pulse
    carry_en = 1'b0;
    do_reset();
    fill(4'b1111, 15);
    carry_en = 1'b1;
    push(4'b0001, 4, 16'h0000, 1);
    press(4'b0001);
    wait_idle(60);
    tick(10);

    // Reset in second STEP cycle aborts chain and drops the other pending press
    carry_en = 1'b0;
    do_reset();
    fill(4'b0111, 15);
    carry_en = 1'b1;
    push(4'b0001, 2, 16'h0000, 0);
    press(4'b0011);
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      if (grant != 4'b0000) seen = 1'b1;
    end
    chk("abort_grant_seen", seen, 1'b1);
    @(posedge clk);
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    chk("abort_cnt", cnt_out, 16'h0000);
    chk("abort_busy", busy, 1'b0);
    seen = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (grant != 4'b0000 || busy) seen = 1'b1;
    end
    chk("abort_no_pending", seen, 1'b0);
    carry_en = 1'b0;

    // DIGITS=2 instance: buttons 2 and 3 are ignored, button 1 is served
    @(posedge clk); #1 pb2 = 4'b1100;
    tick(1); pb2 = 4'b0000;
    seen = 1'b0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (grant2 != 4'b0000 || busy2) seen = 1'b1;
    end
    chk("unused_btn_activity", seen, 1'b0);
    chk("unused_btn_cnt", cnt2, 8'h00);
    @(posedge clk); #1 pb2 = 4'b0010;
    tick(1); pb2 = 4'b0000;
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      if (grant2 != 4'b0000) seen = 1'b1;
    end
    chk("d2_grant", grant2, 4'b0010);
    tick(3);
    @(negedge clk);
    chk("d2_cnt", cnt2, 8'h10);

    chk("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
